// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port ARM register file.
package regfile_pkg;

    localparam int DEF_ADDR_WIDTH = 4;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int CNT_WIDTH      = 8;

    // Index of the architectural register that aliases the program counter.
    function automatic int pc_idx(input int addr_width);
        return (1 << addr_width) - 1;
    endfunction

endpackage

// File: rtl/regfile_word.sv
// One storage word of the register file: async active-low clear, write enable.
module regfile_word #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  we_i,
    input  logic [DATA_WIDTH-1:0] d_i,
    output logic [DATA_WIDTH-1:0] q_o
);

    logic [DATA_WIDTH-1:0] word_q;

    // Hold the word; load on write enable, clear on reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            word_q <= '0;
        end else if (we_i) begin
            word_q <= d_i;
        end
    end

    assign q_o = word_q;

endmodule

// File: rtl/register_file_mp.sv
// Multi-port ARM register file: NUM_RD combinational read ports, two write
// ports (port 0 = ALU result, port 1 = base writeback, port 0 wins on a clash).
// The top index reads PROGCOUNT and ignores writes.
// Optional build macro: REGFILE_BYPASS_EN forwards same-cycle write data to
// matching read ports.
module register_file_mp
    import regfile_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_RD     = 3
) (
    input  logic                         CLK,
    input  logic                         RST_N,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] RA,
    output logic [NUM_RD*DATA_WIDTH-1:0] PA,
    input  logic [ADDR_WIDTH-1:0]        RW0,
    input  logic [DATA_WIDTH-1:0]        PW0,
    input  logic                         LE0,
    input  logic [ADDR_WIDTH-1:0]        RW1,
    input  logic [DATA_WIDTH-1:0]        PW1,
    input  logic                         LE1,
    input  logic [DATA_WIDTH-1:0]        PROGCOUNT,
    output logic                         WR_CONFLICT,
    output logic [CNT_WIDTH-1:0]         CONFLICT_CNT
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;
    localparam int PC_IDX   = pc_idx(ADDR_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] PC_ADDR = ADDR_WIDTH'(PC_IDX);

    // Writes aimed at the PC index are dropped before they reach storage.
    logic wr0_ok;
    logic wr1_ok;
    logic conflict_d;

    assign wr0_ok     = LE0 && (RW0 != PC_ADDR);
    assign wr1_ok     = LE1 && (RW1 != PC_ADDR);
    assign conflict_d = wr0_ok && wr1_ok && (RW0 == RW1);

    // Read view: stored words below the PC index, PROGCOUNT at the PC index.
    logic [DATA_WIDTH-1:0] rd_view [NUM_REGS];

    for (genvar r = 0; r < NUM_REGS - 1; r++) begin : g_reg
        localparam logic [ADDR_WIDTH-1:0] R_ADDR = ADDR_WIDTH'(r);
        logic sel0;
        logic sel1;

        assign sel0 = wr0_ok && (RW0 == R_ADDR);
        assign sel1 = wr1_ok && (RW1 == R_ADDR);

        regfile_word #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_word (
            .clk_i  (CLK),
            .rst_ni (RST_N),
            .we_i   (sel0 | sel1),
            .d_i    (sel0 ? PW0 : PW1),
            .q_o    (rd_view[r])
        );
    end

    assign rd_view[NUM_REGS-1] = PROGCOUNT;

    // Independent read muxes, one per port.
    logic [NUM_RD*DATA_WIDTH-1:0] pa_d;

    always_comb begin
        pa_d = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            logic [ADDR_WIDTH-1:0] ra;
            ra = RA[i*ADDR_WIDTH +: ADDR_WIDTH];
`ifdef REGFILE_BYPASS_EN
            if (wr0_ok && (RW0 == ra)) begin
                pa_d[i*DATA_WIDTH +: DATA_WIDTH] = PW0;
            end else if (wr1_ok && (RW1 == ra)) begin
                pa_d[i*DATA_WIDTH +: DATA_WIDTH] = PW1;
            end else begin
                pa_d[i*DATA_WIDTH +: DATA_WIDTH] = rd_view[ra];
            end
`else
            pa_d[i*DATA_WIDTH +: DATA_WIDTH] = rd_view[ra];
`endif
        end
    end

    assign PA = pa_d;

    // Conflict pulse and saturating conflict counter.
    logic                 wr_conflict_q;
    logic [CNT_WIDTH-1:0] conflict_cnt_q;
    logic [CNT_WIDTH-1:0] conflict_cnt_d;

    assign conflict_cnt_d = (conflict_d && (conflict_cnt_q != {CNT_WIDTH{1'b1}}))
                            ? conflict_cnt_q + 1'b1 : conflict_cnt_q;

    // Register the conflict flag (one-cycle pulse) and the count.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_conflict_q  <= 1'b0;
            conflict_cnt_q <= '0;
        end else begin
            wr_conflict_q  <= conflict_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign WR_CONFLICT  = wr_conflict_q;
    assign CONFLICT_CNT = conflict_cnt_q;

endmodule

// File: tb/tb_register_file_mp.sv
// Self-checking bench for register_file_mp (default and REGFILE_BYPASS_EN builds).
module tb_register_file_mp;

    logic        clk;
    logic        rst_n;
    logic [11:0] ra;
    logic [95:0] pa;
    logic [3:0]  rw0, rw1;
    logic [31:0] pw0, pw1;
    logic        le0, le1;
    logic [31:0] prog;
    logic        wr_conflict;
    logic [7:0]  conflict_cnt;

    register_file_mp dut (
        .CLK          (clk),
        .RST_N        (rst_n),
        .RA           (ra),
        .PA           (pa),
        .RW0          (rw0),
        .PW0          (pw0),
        .LE0          (le0),
        .RW1          (rw1),
        .PW1          (pw1),
        .LE1          (le1),
        .PROGCOUNT    (prog),
        .WR_CONFLICT  (wr_conflict),
        .CONFLICT_CNT (conflict_cnt)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard state and reference model
    logic [31:0] exp_q[$];
    logic [31:0] model [16];
    int          cnt_model;
    int          total = 0;
    int          bad   = 0;

    function automatic logic [31:0] ref_read(input int a);
        return (a == 15) ? prog : model[a];
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 16; i++) model[i] = '0;
        cnt_model = 0;
    endtask

    task automatic set_ra(input int a0, input int a1, input int a2);
        logic [3:0] x0, x1, x2;
        x0 = 4'(a0); x1 = 4'(a1); x2 = 4'(a2);
        ra = {x2, x1, x0};
    endtask

    task automatic test_reset();
        logic [31:0] got, exp;
        rst_n = 1'b0;
        le0 = 0; le1 = 0; rw0 = 0; rw1 = 0; pw0 = 0; pw1 = 0; ra = '0;
        prog = 32'd32;
        clear_model();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int a = 0; a < 16; a++) begin
            @(negedge clk);
            set_ra(a, (a + 5) % 16, (a + 10) % 16);
            exp_q.push_back(ref_read(a));
            exp_q.push_back(ref_read((a + 5) % 16));
            exp_q.push_back(ref_read((a + 10) % 16));
            #1;
            for (int p = 0; p < 3; p++) begin
                got = pa[p*32 +: 32];
                exp = exp_q.pop_front();
                total++;
                if (got !== exp) begin
                    bad++;
                    $display("FAIL reset_read a=%0d port=%0d: got %h expected %h", a, p, got, exp);
                end
            end
        end
        total++;
        if (wr_conflict !== 1'b0 || conflict_cnt !== 8'd0) begin
            bad++;
            $display("FAIL reset_flags: got conflict=%b cnt=%0d expected 0/0", wr_conflict, conflict_cnt);
        end
    endtask

    task automatic test_sweep();
        logic [31:0] got, exp;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            prog = $urandom_range(1000, 50000);
            rw0 = 4'(i); pw0 = 32'(20 + i); le0 = 1'b1;
            @(posedge clk);
            if (i != 15) model[i] = 32'(20 + i);
            @(negedge clk);
            le0 = 1'b0;
            set_ra(i, (i + 15) % 16, 15);
            exp_q.push_back(ref_read(i));
            exp_q.push_back(ref_read((i + 15) % 16));
            exp_q.push_back(ref_read(15));
            #1;
            for (int p = 0; p < 3; p++) begin
                got = pa[p*32 +: 32];
                exp = exp_q.pop_front();
                total++;
                if (got !== exp) begin
                    bad++;
                    $display("FAIL sweep i=%0d port=%0d: got %h expected %h", i, p, got, exp);
                end
            end
        end
    endtask

    task automatic test_dual_write();
        logic [31:0] got, exp;
        @(negedge clk);
        rw0 = 4'd3; pw0 = 32'hAAAA; le0 = 1'b1;
        rw1 = 4'd7; pw1 = 32'h5555; le1 = 1'b1;
        @(posedge clk);
        model[3] = 32'hAAAA;
        model[7] = 32'h5555;
        @(negedge clk);
        le0 = 1'b0; le1 = 1'b0;
        set_ra(3, 7, 15);
        exp_q.push_back(ref_read(3));
        exp_q.push_back(ref_read(7));
        exp_q.push_back(ref_read(15));
        #1;
        for (int p = 0; p < 3; p++) begin
            got = pa[p*32 +: 32];
            exp = exp_q.pop_front();
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL dual_write port=%0d: got %h expected %h", p, got, exp);
            end
        end
        total++;
        if (wr_conflict !== 1'b0) begin
            bad++;
            $display("FAIL dual_no_conflict: got %b expected 0", wr_conflict);
        end
    endtask

    task automatic test_conflict();
        logic [31:0] got, exp;
        // Single same-address clash: port 0 wins, one pulse, count 1.
        @(negedge clk);
        rw0 = 4'd5; pw0 = 32'd1; le0 = 1'b1;
        rw1 = 4'd5; pw1 = 32'd2; le1 = 1'b1;
        @(posedge clk);
        model[5] = 32'd1;
        cnt_model++;
        @(negedge clk);
        le0 = 1'b0; le1 = 1'b0;
        set_ra(5, 5, 5);
        exp_q.push_back(ref_read(5));
        exp_q.push_back(32'd1);
        exp_q.push_back(32'(cnt_model));
        #1;
        got = pa[31:0]; exp = exp_q.pop_front(); total++;
        if (got !== exp) begin bad++; $display("FAIL conflict_winner: got %h expected %h", got, exp); end
        got = 32'(wr_conflict); exp = exp_q.pop_front(); total++;
        if (got !== exp) begin bad++; $display("FAIL conflict_pulse: got %0d expected %0d", got, exp); end
        got = 32'(conflict_cnt); exp = exp_q.pop_front(); total++;
        if (got !== exp) begin bad++; $display("FAIL conflict_cnt1: got %0d expected %0d", got, exp); end
        @(negedge clk);
        total++;
        if (wr_conflict !== 1'b0) begin bad++; $display("FAIL conflict_pulse_end: got %b expected 0", wr_conflict); end

        // Same-address write to the PC index is not a conflict.
        rw0 = 4'd15; rw1 = 4'd15; pw0 = 32'd9; pw1 = 32'd8; le0 = 1'b1; le1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        le0 = 1'b0; le1 = 1'b0;
        total++;
        if (wr_conflict !== 1'b0 || conflict_cnt !== 8'(cnt_model)) begin
            bad++;
            $display("FAIL pc_no_conflict: got %b/%0d expected 0/%0d", wr_conflict, conflict_cnt, cnt_model);
        end

        // 300 back-to-back clashes on varying addresses: counter saturates.
        for (int k = 0; k < 300; k++) begin
            rw0 = 4'($urandom_range(0, 14)); rw1 = rw0;
            pw0 = $urandom; pw1 = $urandom; le0 = 1'b1; le1 = 1'b1;
            @(posedge clk);
            model[rw0] = pw0;
            if (cnt_model < 255) cnt_model++;
            @(negedge clk);
        end
        le0 = 1'b0; le1 = 1'b0;
        exp_q.push_back(32'(cnt_model));
        got = 32'(conflict_cnt); exp = exp_q.pop_front(); total++;
        if (got !== exp || got !== 32'd255) begin
            bad++; $display("FAIL conflict_saturate: got %0d expected %0d", got, exp);
        end
        set_ra(rw0, 15, 0);
        #1;
        got = pa[31:0]; exp = ref_read(rw0); total++;
        if (got !== exp) begin bad++; $display("FAIL conflict_last_data: got %h expected %h", got, exp); end
        @(negedge clk);
        total++;
        if (conflict_cnt !== 8'd255 || wr_conflict !== 1'b0) begin
            bad++; $display("FAIL conflict_hold: got %0d/%b expected 255/0", conflict_cnt, wr_conflict);
        end
    endtask

    task automatic test_read_during_write();
        logic [31:0] got, exp;
        @(negedge clk);
        rw0 = 4'd4; pw0 = 32'h11; le0 = 1'b1;
        @(posedge clk);
        model[4] = 32'h11;
        @(negedge clk);
        rw0 = 4'd4; pw0 = 32'h99; le0 = 1'b1;
        set_ra(4, 6, 15);
`ifdef REGFILE_BYPASS_EN
        exp_q.push_back(32'h99);
`else
        exp_q.push_back(model[4]);
`endif
        #1;
        got = pa[31:0]; exp = exp_q.pop_front(); total++;
        if (got !== exp) begin bad++; $display("FAIL rdw_before: got %h expected %h", got, exp); end
        @(posedge clk);
        model[4] = 32'h99;
        @(negedge clk);
        le0 = 1'b0;
        exp_q.push_back(model[4]);
        #1;
        got = pa[31:0]; exp = exp_q.pop_front(); total++;
        if (got !== exp) begin bad++; $display("FAIL rdw_after: got %h expected %h", got, exp); end
    endtask

    task automatic test_async_reset();
        logic [31:0] got;
        @(negedge clk);
        rw0 = 4'd2; pw0 = 32'h77; le0 = 1'b1;
        set_ra(2, 4, 15);
        #2;
        rst_n = 1'b0;
        clear_model();
        #1;
        got = pa[31:0]; total++;
        if (got !== model[2]) begin bad++; $display("FAIL async_read_now: got %h expected %h", got, model[2]); end
        got = pa[95:64]; total++;
        if (got !== prog) begin bad++; $display("FAIL async_pc: got %h expected %h", got, prog); end
        total++;
        if (conflict_cnt !== 8'd0 || wr_conflict !== 1'b0) begin
            bad++; $display("FAIL async_cnt: got %0d/%b expected 0/0", conflict_cnt, wr_conflict);
        end
        @(posedge clk);
        @(negedge clk);
        got = pa[31:0]; total++;
        if (got !== 32'd0) begin bad++; $display("FAIL async_write_dropped: got %h expected 0", got); end
        le0 = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        got = pa[63:32]; total++;
        if (got !== 32'd0) begin bad++; $display("FAIL async_after_release: got %h expected 0", got); end
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_dual_write();
        test_conflict();
        test_read_during_write();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
